mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide unit, the successor to the fixed 16-bit shift-add multiplier in the execute stage. It adds signed and unsigned modes, radix-2 restoring division, a start/done handshake and a pipeline flush. Results land in HI/LO registers: the product for multiplies, remainder/quotient for divides. Latency is fixed so the pipeline controller can stall deterministically.

Parameters:
WIDTH, 16, operand width in bits (>= 4); the product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
CLK  input  1  system clock; all state changes on the rising edge
Reset  input  1  asynchronous, active-low reset
St  input  1  start request; sampled only in IDLE
Op  input  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS; captured with St
Flush  input  1  synchronous abort to IDLE; no Done is generated
Operand_A  input  WIDTH  multiplicand / dividend; captured with St
Operand_B  input  WIDTH  multiplier / divisor; captured with St
Idle  output  1  high in IDLE only
Busy  output  1  high in PREP, CALC, FIX and DONE
Done  output  1  one-cycle pulse when results are valid
DivZero  output  1  set with Done when a divide had Operand_B == 0; held until next accepted St
Result_Hi  output  WIDTH  MUL: product[2W-1:W]; DIV: remainder
Result_Lo  output  WIDTH  MUL: product[W-1:0]; DIV: quotient

Behaviour:
- Reset low (async): state IDLE, Idle=1, Busy=0, Done=0, DivZero=0, Result_Hi=Result_Lo=0, counter=0.
- FSM: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- Transitions:
  - IDLE: St=1 at an edge latches Op, A and B and moves to PREP; clears DivZero.
  - PREP (1 cycle): computes magnitudes |A| and |B| for signed ops (raw values for unsigned ops), records the result sign(s), sets counter=0.
  - CALC (exactly WIDTH cycles): one shift-add step (MUL) or one shift-subtract-restore step (DIV) per cycle; leaves CALC when counter==WIDTH-1.
  - FIX (1 cycle): negates results as needed and writes Result_Hi/Lo.
  - DONE (1 cycle): Done=1, then returns to IDLE.
- Latency: if St is sampled at edge 0, Done is high between edges WIDTH+2 and WIDTH+3. This is constant for all ops, including divide-by-zero.
- Results are held stable from FIX until the FIX of the next accepted operation.
- St while Busy is ignored; there is no queuing.
- Signed rules:
  - Product sign = sign(A) XOR sign(B).
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - |MIN| = 2^(W-1) is handled as an unsigned magnitude.
- Overflow: DIVS MIN / -1 gives Lo = MIN (two's-complement wrap) and Hi = 0. No flag is raised.
- Divide by zero (DIVU or DIVS): Lo = all ones, Hi = Operand_A unchanged, DivZero=1 in the DONE cycle and held afterwards.
- Flush=1 in any state: at the next edge go to IDLE. Result_Hi/Lo and DivZero keep their previous values and Done is not pulsed.
  - Flush has priority over St in the same cycle (St is dropped).
- Reset asserted mid-operation: immediate return to reset values; no Done.

Optional Feature:
MUL_DIV_UNIT_DIV_EN
- Defined: full behaviour above.
- Undefined: divider datapath removed.
  - Op 10/11 still follow the full FSM with identical latency.
  - They produce Result_Hi = Result_Lo = 0.
  - DivZero is tied to 0.
  - MUL ops are unaffected.

Test Plan:
1. MULU A=0xFFFF, B=0xFFFF, St pulse at edge 0 -> Done high after edge 18 only; Hi=0xFFFE, Lo=0x0001; Idle again after edge 19.
2. MULS A=0xFFFD (-3), B=0x0007 -> Hi=0xFFFF, Lo=0xFFEB (-21). Also MULS 0x8000*0x8000 -> Hi=0x4000, Lo=0x0000.
3. DIVS A=0xFFF9 (-7), B=0x0002 -> Lo=0xFFFD (-3), Hi=0xFFFF (-1). DIVS 0x8000/0xFFFF -> Lo=0x8000, Hi=0x0000, DivZero=0.
4. DIVU A=0x0064, B=0x0000 -> Lo=0xFFFF, Hi=0x0064, DivZero=1 in the Done cycle and held. The next accepted St clears DivZero.
5. Start MULU 3*5, assert Flush at edge 8 -> Idle after edge 8, no Done, Results keep prior values. Separately, St pulsed during CALC -> ignored, only one Done.
6. Drive Reset low mid-CALC -> all outputs at reset values immediately, no Done. With the macro undefined, DIVU 100/7 -> Done at edge 18, Hi=Lo=0, DivZero=0.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - start/done handshake and result bus of the multiply/divide unit
interface mul_div_unit_if #(
  parameter int WIDTH = 16
);
  logic             St;
  logic [1:0]       Op;
  logic             Flush;
  logic [WIDTH-1:0] Operand_A;
  logic [WIDTH-1:0] Operand_B;
  logic             Idle;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Result_Hi;
  logic [WIDTH-1:0] Result_Lo;

  modport master (
    output St, Op, Flush, Operand_A, Operand_B,
    input  Idle, Busy, Done, DivZero, Result_Hi, Result_Lo
  );

  modport slave (
    input  St, Op, Flush, Operand_A, Operand_B,
    output Idle, Busy, Done, DivZero, Result_Hi, Result_Lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative signed/unsigned multiply/divide unit; divider enabled by MUL_DIV_UNIT_DIV_EN
module mul_div_unit #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic           CLK,
  input logic           Reset,
  mul_div_unit_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic             idle_q, busy_q, done_q, dz_q;
  logic [WIDTH-1:0] res_hi_q, res_lo_q;
  // hi_q:lo_q is the working pair: product accumulator (MUL) or remainder:quotient (DIV).
  // lo_q/m_q hold the raw A/B during PREP, then the magnitudes.
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic             neg_p_q;   // product / quotient must be negated
  logic             neg_r_q;   // remainder must be negated (dividend sign)

  logic               sign_a_d, sign_b_d;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] prod_d, prod_neg_d;

  assign sign_a_d   = op_q[0] & lo_q[WIDTH-1];
  assign sign_b_d   = op_q[0] & m_q[WIDTH-1];
  assign mul_sum_d  = {1'b0, hi_q} + {1'b0, m_q};
  assign prod_d     = {hi_q, lo_q};
  assign prod_neg_d = -prod_d;

`ifdef MUL_DIV_UNIT_DIV_EN
  logic           bz_q;       // divisor was zero
  logic [WIDTH:0] rem_sh_d, rem_sub_d;
  logic           rem_ge_d;

  assign rem_sh_d  = {hi_q, lo_q[WIDTH-1]};
  assign rem_sub_d = rem_sh_d - {1'b0, m_q};
  assign rem_ge_d  = rem_sh_d >= {1'b0, m_q};
`endif

  assign bus.Idle      = idle_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DivZero   = dz_q;
  assign bus.Result_Hi = res_hi_q;
  assign bus.Result_Lo = res_lo_q;

  // Control FSM and datapath: one step per cycle in CALC, registered status outputs
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      idle_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      bz_q     <= 1'b0;
`endif
    end else if (bus.Flush) begin
      // abort wins over everything, results and DivZero are left untouched
      state_q <= S_IDLE;
      idle_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.St) begin
            op_q    <= bus.Op;
            lo_q    <= bus.Operand_A;
            m_q     <= bus.Operand_B;
            dz_q    <= 1'b0;
            idle_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          // |MIN| wraps to 2^(W-1), which is the correct unsigned magnitude
          lo_q    <= sign_a_d ? -lo_q : lo_q;
          m_q     <= sign_b_d ? -m_q : m_q;
          hi_q    <= '0;
          neg_p_q <= sign_a_d ^ sign_b_d;
          neg_r_q <= sign_a_d;
`ifdef MUL_DIV_UNIT_DIV_EN
          bz_q    <= op_q[1] & (m_q == '0);
`endif
          cnt_q   <= '0;
          state_q <= S_CALC;
        end
        S_CALC: begin
`ifdef MUL_DIV_UNIT_DIV_EN
          if (op_q[1]) begin
            // restoring step: subtract only when the shifted remainder covers the divisor
            hi_q <= rem_ge_d ? rem_sub_d[WIDTH-1:0] : rem_sh_d[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], rem_ge_d};
          end else
`endif
          if (lo_q[0]) begin
            hi_q <= mul_sum_d[WIDTH:1];
            lo_q <= {mul_sum_d[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_q <= {1'b0, hi_q[WIDTH-1:1]};
            lo_q <= {hi_q[0], lo_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (!op_q[1]) begin
            {res_hi_q, res_lo_q} <= neg_p_q ? prod_neg_d : prod_d;
          end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
            // with a zero divisor the remainder path already yields the dividend
            res_hi_q <= neg_r_q ? -hi_q : hi_q;
            res_lo_q <= bz_q ? '1 : (neg_p_q ? -lo_q : lo_q);
            dz_q     <= bz_q;
`else
            res_hi_q <= '0;
            res_lo_q <= '0;
`endif
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          idle_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          idle_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
